// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target receiver.
package i2c_pkg;
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, STRETCH, DATA_ACK, IGNORE
  } tgt_state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_ACK      = 1'b0;

  typedef logic [7:0] i2c_byte_t;
endpackage

// File: rtl/i2c_line_filter.sv
// One bus line: 2-FF synchronizer, optional counter glitch filter
// (I2C_TGT_FILTER_EN), and edge pulses from current vs previous level.
module i2c_line_filter #(
  parameter int FILT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [1:0] sync;
  logic       lvl_q;

  // Lines idle high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], din};
  end

`ifdef I2C_TGT_FILTER_EN
  localparam int CW = $clog2(FILT + 1);
  logic [CW-1:0] cnt;
  logic          flt;

  // Level follows the input only after FILT consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      flt <= 1'b1;
    end else if (sync[1] == flt) begin
      cnt <= '0;
    end else if (cnt == CW'(FILT - 1)) begin
      flt <= sync[1];
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
  assign level = flt;
`else
  logic unused_filt;
  assign unused_filt = (FILT > 0);
  assign level = sync[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvl_q <= 1'b1;
    else     lvl_q <= level;
  end

  assign rise = level & ~lvl_q;
  assign fall = ~level & lvl_q;
endmodule

// File: rtl/i2c_target_rx.sv
// I2C write-only target: address match, byte receive, clock stretch until the
// consumer takes each byte, then ACK. Input filter via I2C_TGT_FILTER_EN.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter int TSU  = 8,
  parameter int FILT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic [6:0] own_addr,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_first,
  output logic       stop_det,
  output logic       busy
);
  localparam int TW = $clog2(TSU + 1);

  logic scl_lvl, scl_rise_raw, scl_fall_raw;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILT(FILT)) u_scl (
    .clk(clk), .rst(rst), .din(scl_in),
    .level(scl_lvl), .rise(scl_rise_raw), .fall(scl_fall_raw)
  );

  i2c_line_filter #(.FILT(FILT)) u_sda (
    .clk(clk), .rst(rst), .din(sda_in),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  // While we hold SCL low our own pull-down must not look like bus clocking.
  logic scl_rise, scl_fall, start_c, stop_c;
  assign scl_rise = scl_rise_raw & ~scl_oe;
  assign scl_fall = scl_fall_raw & ~scl_oe;
  assign start_c  = sda_fall & scl_lvl;
  assign stop_c   = sda_rise & scl_lvl;

  tgt_state_t    state;
  logic [2:0]    bit_cnt;
  i2c_byte_t     shreg;
  i2c_byte_t     shift_next;
  logic          byte_full;
  logic          first_flag;
  logic [TW-1:0] tsu_cnt;

  assign shift_next = {shreg[6:0], sda_lvl};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_full  <= 1'b0;
      first_flag <= 1'b0;
      tsu_cnt    <= '0;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      stop_det   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      stop_det <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (start_c || stop_c) begin
        // A pending rx byte survives; only bus-side state is dropped.
        scl_oe    <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        bit_cnt   <= '0;
        byte_full <= 1'b0;
        tsu_cnt   <= '0;
        stop_det  <= stop_c;
        state     <= stop_c ? IDLE : ADDR;
      end else begin
        case (state)
          IDLE: ;

          ADDR: if (scl_rise) begin
            shreg   <= shift_next;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              if (shift_next[7:1] == own_addr && shift_next[0] == I2C_RW_WRITE) begin
                busy  <= 1'b1;
                state <= ADDR_ACK;
              end else begin
                state <= IGNORE;
              end
            end
          end

          ADDR_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe     <= 1'b0;
              bit_cnt    <= '0;
              byte_full  <= 1'b0;
              first_flag <= 1'b1;
              state      <= DATA;
            end
          end

          DATA: begin
            if (scl_rise) begin
              shreg   <= shift_next;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) byte_full <= 1'b1;
            end else if (scl_fall && byte_full) begin
              scl_oe     <= 1'b1;
              rx_data    <= shreg;
              rx_first   <= first_flag;
              rx_valid   <= 1'b1;
              first_flag <= 1'b0;
              byte_full  <= 1'b0;
              tsu_cnt    <= '0;
              state      <= STRETCH;
            end
          end

          // sda_oe doubles as "byte taken, ACK setup time running".
          STRETCH: begin
            if (rx_valid && rx_ready) begin
              sda_oe <= 1'b1;
            end else if (sda_oe) begin
              if (tsu_cnt == TW'(TSU - 1)) begin
                scl_oe <= 1'b0;
                state  <= DATA_ACK;
              end else begin
                tsu_cnt <= tsu_cnt + 1'b1;
              end
            end
          end

          DATA_ACK: if (scl_fall) begin
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
            state   <= DATA;
          end

          IGNORE: ;

          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
